// File: rtl/clk_phase_pkg.sv
// Shared types and constants for the quadrature phase checker.
// The optional sticky error flag is enabled with CLK_PHASE_CHK_STICKY_EN.
package clk_phase_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Legal {clk_270, clk_180, clk_90, clk_0} vectors, one per quarter period
    localparam logic [3:0] PH_0   = 4'b1001;
    localparam logic [3:0] PH_90  = 4'b0011;
    localparam logic [3:0] PH_180 = 4'b0110;
    localparam logic [3:0] PH_270 = 4'b1100;

    function automatic logic [3:0] rotl4(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/clk_phase_checker_if.sv
// Bus between the quadrature source side and the phase checker.
// The sticky_err signal exists only when CLK_PHASE_CHK_STICKY_EN is defined.
interface clk_phase_checker_if #(
    parameter int ERR_W = 8
);

    logic [3:0]       phase_in;
    logic             clr;
    logic             locked;
    logic [1:0]       phase_idx;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
`ifdef CLK_PHASE_CHK_STICKY_EN
    logic             sticky_err;

    modport master (
        output phase_in, clr,
        input  locked, phase_idx, err_pulse, err_cnt, sticky_err
    );

    modport slave (
        input  phase_in, clr,
        output locked, phase_idx, err_pulse, err_cnt, sticky_err
    );
`else
    modport master (
        output phase_in, clr,
        input  locked, phase_idx, err_pulse, err_cnt
    );

    modport slave (
        input  phase_in, clr,
        output locked, phase_idx, err_pulse, err_cnt
    );
`endif

endinterface

// File: rtl/clk_phase_decode.sv
// Combinational decode of a sampled quadrature vector into legality and phase index.
// Used by the checker with or without CLK_PHASE_CHK_STICKY_EN.
module clk_phase_decode
    import clk_phase_pkg::*;
(
    input  logic [3:0] vec,
    output logic       legal,
    output logic [1:0] idx
);

    always_comb begin
        legal = 1'b0;
        idx   = 2'd0;
        case (vec)
            PH_0: begin
                legal = 1'b1;
                idx   = 2'd0;
            end
            PH_90: begin
                legal = 1'b1;
                idx   = 2'd1;
            end
            PH_180: begin
                legal = 1'b1;
                idx   = 2'd2;
            end
            PH_270: begin
                legal = 1'b1;
                idx   = 2'd3;
            end
            default: begin
                legal = 1'b0;
                idx   = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/clk_phase_checker.sv
// Monitors the clk_phase quadrature outputs, declares lock and counts sequence errors.
// Define CLK_PHASE_CHK_STICKY_EN to add a sticky error flag cleared only by clr or reset.
module clk_phase_checker
    import clk_phase_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int ERR_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    clk_phase_checker_if.slave  bus
);

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);

    logic [3:0]       s_q;
    logic [3:0]       p_q;
    logic             s_legal;
    logic [1:0]       s_idx;
    logic             legal_trans;
    logic             err_event;

    state_t           state;
    logic [7:0]       good_cnt;
    logic             locked_q;
    logic [1:0]       idx_q;
    logic             pulse_q;
    logic [ERR_W-1:0] err_q;
    logic [ERR_W-1:0] err_next;

    // Source shares clk, so two plain sample stages give current and previous vectors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q <= 4'b0000;
            p_q <= 4'b0000;
        end else begin
            s_q <= bus.phase_in;
            p_q <= s_q;
        end
    end

    clk_phase_decode u_decode (
        .vec   (s_q),
        .legal (s_legal),
        .idx   (s_idx)
    );

    assign legal_trans = s_legal && (s_q == rotl4(p_q));
    assign err_event   = (state == LOCKED) && !legal_trans;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SEARCH;
            good_cnt <= 8'd0;
            locked_q <= 1'b0;
            idx_q    <= 2'd0;
            pulse_q  <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            case (state)
                SEARCH: begin
                    idx_q <= 2'd0;
                    if (legal_trans) begin
                        if (good_cnt == LOCK_LAST) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            good_cnt <= 8'd0;
                            idx_q    <= s_idx;
                        end else begin
                            good_cnt <= good_cnt + 8'd1;
                        end
                    end else begin
                        good_cnt <= 8'd0;
                    end
                end
                LOCKED: begin
                    if (legal_trans) begin
                        idx_q <= s_idx;
                    end else begin
                        state    <= SEARCH;
                        locked_q <= 1'b0;
                        pulse_q  <= 1'b1;
                        good_cnt <= 8'd0;
                        idx_q    <= 2'd0;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    locked_q <= 1'b0;
                    good_cnt <= 8'd0;
                    idx_q    <= 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        err_next = err_q;
        if (err_event && (err_q != {ERR_W{1'b1}})) begin
            err_next = err_q + ERR_W'(1);
        end
    end

    // A clear that lands on an error cycle still records that one error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else if (bus.clr) begin
            err_q <= err_event ? ERR_W'(1) : '0;
        end else begin
            err_q <= err_next;
        end
    end

`ifdef CLK_PHASE_CHK_STICKY_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_q <= 1'b0;
        end else if (err_event) begin
            sticky_q <= 1'b1;
        end else if (bus.clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus.sticky_err = sticky_q;
`endif

    assign bus.locked    = locked_q;
    assign bus.phase_idx = idx_q;
    assign bus.err_pulse = pulse_q;
    assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_clk_phase_checker.sv
// Directed self-checking bench for clk_phase_checker (wide and 2-bit error counters).
// Sticky checks are included when CLK_PHASE_CHK_STICKY_EN is defined.
module tb_clk_phase_checker;

    localparam int LOCK = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ph       = 0;

    always #5 clk = ~clk;

    clk_phase_checker_if #(.ERR_W(8)) bus_a ();
    clk_phase_checker_if #(.ERR_W(2)) bus_b ();

    clk_phase_checker #(.LOCK_CNT(LOCK), .ERR_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    clk_phase_checker #(.LOCK_CNT(LOCK), .ERR_W(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    function automatic logic [3:0] vec_of(input int k);
        case (k % 4)
            0:       return 4'b1001;
            1:       return 4'b0011;
            2:       return 4'b0110;
            default: return 4'b1100;
        endcase
    endfunction

    task automatic check_output(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    // Inputs change on the falling edge; outputs are read 1 unit after the rising edge
    task automatic apply_stimulus(input logic [3:0] v, input logic c);
        @(negedge clk);
        bus_a.phase_in = v;
        bus_b.phase_in = v;
        bus_a.clr      = c;
        bus_b.clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_clean();
        apply_stimulus(vec_of(ph), 1'b0);
        ph++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus_a.phase_in = 4'b0000;
        bus_b.phase_in = 4'b0000;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic clean_lock_check(input string tag);
        ph = 0;
        for (int i = 1; i <= LOCK + 2; i++) begin
            apply_clean();
            if (i == LOCK + 1) check_output({tag, "_early"}, int'(bus_a.locked), 0);
        end
        check_output({tag, "_locked_a"}, int'(bus_a.locked), 1);
        check_output({tag, "_locked_b"}, int'(bus_b.locked), 1);
        check_output({tag, "_idx0"}, int'(bus_a.phase_idx), LOCK % 4);
        for (int i = 0; i < 4; i++) begin
            apply_clean();
            check_output({tag, "_idx_run"}, int'(bus_a.phase_idx), (ph - 2) % 4);
        end
    endtask

    task automatic lock_up(input string tag);
        for (int i = 0; i < 40 && !bus_a.locked; i++) apply_clean();
        check_output({tag, "_lock_up"}, int'(bus_a.locked), 1);
    endtask

    task automatic break_lock();
        apply_stimulus(4'b0000, 1'b0);
        apply_stimulus(4'b0000, 1'b0);
    endtask

    initial begin
        logic [3:0] rev [4];
        logic       seen_lock;

        rev[0] = 4'b1001;
        rev[1] = 4'b1100;
        rev[2] = 4'b0110;
        rev[3] = 4'b0011;
        bus_a.phase_in = 4'b0000;
        bus_b.phase_in = 4'b0000;
        bus_a.clr      = 1'b0;
        bus_b.clr      = 1'b0;

        #20;
        check_output("rst_locked", int'(bus_a.locked), 0);
        check_output("rst_idx", int'(bus_a.phase_idx), 0);
        check_output("rst_pulse", int'(bus_a.err_pulse), 0);
        check_output("rst_errcnt", int'(bus_a.err_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        clean_lock_check("clean");
        check_output("clean_errcnt", int'(bus_a.err_cnt), 0);

        // Stuck input: hold 0011 after it appeared legally
        while (vec_of(ph - 1) != 4'b0011) apply_clean();
        apply_stimulus(4'b0011, 1'b0);
        apply_stimulus(4'b0011, 1'b0);
        check_output("stuck_pulse", int'(bus_a.err_pulse), 1);
        check_output("stuck_locked", int'(bus_a.locked), 0);
        check_output("stuck_errcnt", int'(bus_a.err_cnt), 1);
        check_output("stuck_idx", int'(bus_a.phase_idx), 0);
        apply_stimulus(4'b0011, 1'b0);
        check_output("stuck_pulse_once", int'(bus_a.err_pulse), 0);
        check_output("stuck_errcnt_hold", int'(bus_a.err_cnt), 1);
        ph = 2;
        for (int i = 0; i < LOCK; i++) apply_clean();
        check_output("relock_early", int'(bus_a.locked), 0);
        apply_clean();
        check_output("relock", int'(bus_a.locked), 1);

        // Reverse rotation never locks
        do_reset();
        seen_lock = 1'b0;
        for (int i = 0; i < 24; i++) begin
            apply_stimulus(rev[i % 4], 1'b0);
            seen_lock = seen_lock | bus_a.locked;
        end
        check_output("reverse_lock", int'(seen_lock), 0);
        check_output("reverse_errcnt", int'(bus_a.err_cnt), 0);

        // Five lock/error cycles saturate the 2-bit counter
        for (int i = 0; i < 5; i++) begin
            lock_up("sat");
            break_lock();
        end
        check_output("sat_errcnt_a", int'(bus_a.err_cnt), 5);
        check_output("sat_errcnt_b", int'(bus_b.err_cnt), 3);
        apply_stimulus(vec_of(ph), 1'b1);
        ph++;
        check_output("clr_errcnt_a", int'(bus_a.err_cnt), 0);
        check_output("clr_errcnt_b", int'(bus_b.err_cnt), 0);
        lock_up("clrerr");
        apply_stimulus(4'b0000, 1'b0);
        apply_stimulus(4'b0000, 1'b1);
        check_output("clrerr_pulse", int'(bus_a.err_pulse), 1);
        check_output("clrerr_errcnt_a", int'(bus_a.err_cnt), 1);
        check_output("clrerr_errcnt_b", int'(bus_b.err_cnt), 1);
`ifdef CLK_PHASE_CHK_STICKY_EN
        check_output("sticky_set", int'(bus_a.sticky_err), 1);
        apply_stimulus(4'b0000, 1'b0);
        lock_up("sticky");
        check_output("sticky_persist", int'(bus_a.sticky_err), 1);
        apply_stimulus(vec_of(ph), 1'b1);
        ph++;
        check_output("sticky_clr", int'(bus_a.sticky_err), 0);
        check_output("sticky_clr_locked", int'(bus_a.locked), 1);
`else
        apply_stimulus(4'b0000, 1'b0);
`endif

        // Asynchronous reset while locked
        lock_up("midrst");
        @(posedge clk);
        #2;
        rst = 1'b0;
        bus_a.phase_in = 4'b0000;
        bus_b.phase_in = 4'b0000;
        #1;
        check_output("midrst_locked", int'(bus_a.locked), 0);
        check_output("midrst_errcnt", int'(bus_a.err_cnt), 0);
        check_output("midrst_pulse", int'(bus_a.err_pulse), 0);
`ifdef CLK_PHASE_CHK_STICKY_EN
        check_output("midrst_sticky", int'(bus_a.sticky_err), 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        clean_lock_check("after_rst");

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
